// File: rtl/rcu_cfg_seq_pkg.sv
// Shared types and constants for the RCU clock-reconfiguration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rcu_cfg_seq_pkg;

   localparam int RCU_CLK_CFG_WIDTH  = 3;
   localparam int RCU_CORE_SEL_WIDTH = 5;

   // Core select code of the always-running bypass/oscillator clock.
   localparam logic [RCU_CORE_SEL_WIDTH-1:0] RCU_CORE_SEL_BYPASS = 5'd1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PARK    = 3'd1,
      ST_PLL_OFF = 3'd2,
      ST_CFG     = 3'd3,
      ST_PLL_ON  = 3'd4,
      ST_SWITCH  = 3'd5,
      ST_ERR     = 3'd6
   } rcu_seq_state_e;

   // Used to size the shared step/timeout counter from the largest parameter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rcu_cfg_seq_if.sv
// Request/config/feedback bundle between the RCU register block, the sequencer and the RCU core.
// Latency: n/a (wires only).
// Backpressure: none; start is a level sampled by the sequencer only when idle.
// master: register block / RCU side (drives requests, lock and feedback).
// slave : sequencer side (drives pll_en, clk_cfg, core_sel and status).
interface rcu_cfg_seq_if;
   import rcu_cfg_seq_pkg::*;

   logic                          start_i;
   logic [RCU_CLK_CFG_WIDTH-1:0]  tgt_cfg_i;
   logic [RCU_CORE_SEL_WIDTH-1:0] tgt_sel_i;
   logic                          pll_lock_i;
   logic [RCU_CORE_SEL_WIDTH-1:0] core_sel_fb_i;
   logic                          pll_en_o;
   logic [RCU_CLK_CFG_WIDTH-1:0]  clk_cfg_o;
   logic [RCU_CORE_SEL_WIDTH-1:0] core_sel_o;
   logic                          busy_o;
   logic                          done_o;
   logic                          err_o;

   modport master (
      output start_i, tgt_cfg_i, tgt_sel_i, pll_lock_i, core_sel_fb_i,
      input  pll_en_o, clk_cfg_o, core_sel_o, busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, tgt_cfg_i, tgt_sel_i, pll_lock_i, core_sel_fb_i,
      output pll_en_o, clk_cfg_o, core_sel_o, busy_o, done_o, err_o
   );

endinterface

// File: rtl/rcu_sync2.sv
// Two-flop synchronizer for asynchronous RCU status inputs (PLL lock and similar).
// Latency: 2 cycles of i_clk.
// Backpressure: none.
// Ports: i_clk, i_rst (async active-high, output resets to 0), i_d async input, o_q synchronized output.
module rcu_sync2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/rcu_cfg_seq.sv
// Sequences a PLL reconfiguration: park core on bypass, PLL off, apply cfg, PLL on, wait stable lock, switch core.
// Latency: 1 + 2*SETTLE_CYC + 2 + LOCK_STABLE + 1 cycles from accepted start to done with immediate feedback and lock.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, never queued.
// Ports: clk_i (always-running bypass clock), rst_i (async active-high), bus (slave side of rcu_cfg_seq_if).
module rcu_cfg_seq
   import rcu_cfg_seq_pkg::*;
#(
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned LOCK_STABLE = 8,
   parameter int unsigned LOCK_TMO    = 4096
) (
   input  logic          clk_i,
   input  logic          rst_i,
   rcu_cfg_seq_if.slave  bus
);

   localparam int unsigned MAXP = max3(SETTLE_CYC, LOCK_STABLE, LOCK_TMO);
   localparam int unsigned CW   = $clog2(MAXP) + 1;

   // Exit compares are against N-1: the counter is 0 in the first cycle of a state.
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TMO - 1);

   rcu_seq_state_e                r_state;
   rcu_seq_state_e                w_state_nxt;
   logic [CW-1:0]                 r_cnt;
   logic [CW-1:0]                 r_stb;
   logic                          w_lock;

   logic                          r_pll_en;
   logic [RCU_CLK_CFG_WIDTH-1:0]  r_clk_cfg;
   logic [RCU_CORE_SEL_WIDTH-1:0] r_core_sel;
   logic                          r_busy;
   logic                          r_done;
   logic                          r_err;
   logic [RCU_CLK_CFG_WIDTH-1:0]  r_tgt_cfg;
   logic [RCU_CORE_SEL_WIDTH-1:0] r_tgt_sel;

   logic                          w_pll_en_nxt;
   logic [RCU_CLK_CFG_WIDTH-1:0]  w_clk_cfg_nxt;
   logic [RCU_CORE_SEL_WIDTH-1:0] w_core_sel_nxt;
   logic                          w_busy_nxt;
   logic                          w_done_nxt;
   logic                          w_err_nxt;
   logic                          w_latch;

   rcu_sync2 u_lock_sync (
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_d   (bus.pll_lock_i),
      .o_q   (w_lock)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Outputs are computed for the next state and registered, so every state
   // drives its outputs from its first cycle.
   always_comb begin
      w_state_nxt    = r_state;
      w_pll_en_nxt   = r_pll_en;
      w_clk_cfg_nxt  = r_clk_cfg;
      w_core_sel_nxt = r_core_sel;
      w_done_nxt     = 1'b0;
      w_err_nxt      = r_err;
      w_latch        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start_i) begin
               w_latch        = 1'b1;
               w_err_nxt      = 1'b0;
               w_core_sel_nxt = RCU_CORE_SEL_BYPASS;
               w_state_nxt    = ST_PARK;
            end
         end
         ST_PARK: begin
            w_core_sel_nxt = RCU_CORE_SEL_BYPASS;
            if (bus.core_sel_fb_i == RCU_CORE_SEL_BYPASS) begin
               w_pll_en_nxt = 1'b0;
               w_state_nxt  = ST_PLL_OFF;
            end
         end
         ST_PLL_OFF: begin
            w_pll_en_nxt = 1'b0;
            if (r_cnt == SETTLE_LAST) begin
               w_clk_cfg_nxt = r_tgt_cfg;
               w_state_nxt   = ST_CFG;
            end
         end
         ST_CFG: begin
            w_clk_cfg_nxt = r_tgt_cfg;
            if (r_cnt == SETTLE_LAST) begin
               w_pll_en_nxt = 1'b1;
               w_state_nxt  = ST_PLL_ON;
            end
         end
         ST_PLL_ON: begin
            w_pll_en_nxt = 1'b1;
            // Lock is tested first so it wins a tie with the timeout.
            if (w_lock && (r_stb == STABLE_LAST)) begin
               w_core_sel_nxt = r_tgt_sel;
               w_state_nxt    = ST_SWITCH;
            end else if (r_cnt == TMO_LAST) begin
               w_pll_en_nxt   = 1'b0;
               w_core_sel_nxt = RCU_CORE_SEL_BYPASS;
               w_err_nxt      = 1'b1;
               w_state_nxt    = ST_ERR;
            end
         end
         ST_SWITCH: begin
            w_core_sel_nxt = r_tgt_sel;
            if (bus.core_sel_fb_i == r_tgt_sel) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (!w_lock) begin
               w_pll_en_nxt   = 1'b0;
               w_core_sel_nxt = RCU_CORE_SEL_BYPASS;
               w_err_nxt      = 1'b1;
               w_state_nxt    = ST_ERR;
            end
         end
         ST_ERR: begin
            w_pll_en_nxt   = 1'b0;
            w_core_sel_nxt = RCU_CORE_SEL_BYPASS;
            w_err_nxt      = 1'b1;
            w_state_nxt    = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_ERR);
   end

   // r_cnt: settle time in PLL_OFF/CFG, timeout in PLL_ON.
   // r_stb: consecutive synchronized-lock-high cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
         r_stb <= '0;
      end else if (w_state_nxt != r_state) begin
         r_cnt <= '0;
         r_stb <= '0;
      end else begin
         if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
         if (!w_lock)          r_stb <= '0;
         else if (r_stb != '1) r_stb <= r_stb + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_pll_en   <= 1'b0;
         r_clk_cfg  <= '0;
         r_core_sel <= RCU_CORE_SEL_BYPASS;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_tgt_cfg  <= '0;
         r_tgt_sel  <= RCU_CORE_SEL_BYPASS;
      end else begin
         r_pll_en   <= w_pll_en_nxt;
         r_clk_cfg  <= w_clk_cfg_nxt;
         r_core_sel <= w_core_sel_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
         if (w_latch) begin
            r_tgt_cfg <= bus.tgt_cfg_i;
            r_tgt_sel <= bus.tgt_sel_i;
         end
      end
   end

   assign bus.pll_en_o   = r_pll_en;
   assign bus.clk_cfg_o  = r_clk_cfg;
   assign bus.core_sel_o = r_core_sel;
   assign bus.busy_o     = r_busy;
   assign bus.done_o     = r_done;
   assign bus.err_o      = r_err;

endmodule

// File: tb/tb_rcu_cfg_seq.sv
// Directed bench for rcu_cfg_seq: scoreboard of expected outcomes per accepted start.
// Latency: n/a.
// Backpressure: n/a.
module tb_rcu_cfg_seq;
   import rcu_cfg_seq_pkg::*;

   localparam int SETTLE = 16;
   localparam int STABLE = 8;
   localparam int TMO    = 64;

   typedef struct packed {
      logic       err;
      logic [2:0] cfg;
      logic [4:0] sel;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i;

   rcu_cfg_seq_if bus ();

   rcu_cfg_seq #(
      .SETTLE_CYC  (SETTLE),
      .LOCK_STABLE (STABLE),
      .LOCK_TMO    (TMO)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_bad  = 0;
   int   n_done = 0;

   // Lock model: 0 follows pll_en after lk_delay cycles, 1 held low, 2 high 5 / low 1.
   int         lk_mode  = 0;
   int         lk_delay = 0;
   // Feedback model: 0 immediate mirror, 1 one-cycle-late mirror, 2 held at fb_hold.
   int         fb_mode  = 0;
   logic [4:0] fb_hold  = 5'd1;
   int         en_cnt   = 0;
   logic [4:0] last_sel = 5'd1;

   // Environment: RCU lock and select feedback, updated just after each edge.
   initial begin
      bus.pll_lock_i    = 1'b0;
      bus.core_sel_fb_i = 5'd1;
      forever begin
         @(posedge clk_i);
         #1;
         if (bus.pll_en_o) en_cnt = en_cnt + 1;
         else              en_cnt = 0;
         case (lk_mode)
            0:       bus.pll_lock_i = (en_cnt > lk_delay);
            2:       bus.pll_lock_i = (en_cnt > 0) && (((en_cnt - 1) % 6) != 5);
            default: bus.pll_lock_i = 1'b0;
         endcase
         case (fb_mode)
            0:       bus.core_sel_fb_i = bus.core_sel_o;
            1:       bus.core_sel_fb_i = last_sel;
            default: bus.core_sel_fb_i = fb_hold;
         endcase
         last_sel = bus.core_sel_o;
         if (bus.done_o) n_done = n_done + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      assert (obs === exp) else begin
         n_bad = n_bad + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic do_start(input logic [2:0] c, input logic [4:0] s);
      bus.start_i   = 1'b1;
      bus.tgt_cfg_i = c;
      bus.tgt_sel_i = s;
      tick();
      bus.start_i   = 1'b0;
   endtask

   // which: 0 pll_en_o, 1 core_sel_o, 2 clk_cfg_o
   task automatic wait_sig(input int which, input logic [4:0] val, input int budget, input string tag);
      int   n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < budget) begin
         case (which)
            0:       hit = (bus.pll_en_o == val[0]);
            1:       hit = (bus.core_sel_o == val);
            default: hit = (bus.clk_cfg_o == val[2:0]);
         endcase
         if (!hit) begin
            tick();
            n = n + 1;
         end
      end
      chk({tag, "_reached"}, hit, 1);
   endtask

   task automatic wait_end(input int budget, input string tag);
      int n;
      n = 0;
      while (!(bus.done_o || bus.err_o) && n < budget) begin
         tick();
         n = n + 1;
      end
      chk({tag, "_end"}, bus.done_o || bus.err_o, 1);
   endtask

   task automatic outcome(input string tag);
      exp_t e;
      chk({tag, "_sb_depth"}, sb.size(), 1);
      if (sb.size() > 0) e = sb.pop_front();
      else               e = '1;
      chk({tag, "_result"}, {bus.err_o, bus.clk_cfg_o, bus.core_sel_o}, e);
      chk({tag, "_pll_en"}, bus.pll_en_o, !e.err);
      tick();
      chk({tag, "_done_after"}, bus.done_o, 0);
      chk({tag, "_busy_after"}, bus.busy_o, 0);
   endtask

   localparam logic [9:0] RST_VEC = {1'b0, 3'd0, 5'd1, 1'b0};

   initial begin
      int         n;
      int         d0;
      int         chg;
      logic [4:0] prev;

      rst_i         = 1'b1;
      bus.start_i   = 1'b0;
      bus.tgt_cfg_i = 3'd0;
      bus.tgt_sel_i = 5'd0;
      tick();
      tick();
      chk("reset_outs", {bus.pll_en_o, bus.clk_cfg_o, bus.core_sel_o, bus.busy_o}, RST_VEC);
      chk("reset_flags", {bus.done_o, bus.err_o}, 2'b00);
      rst_i = 1'b0;
      tick();
      tick();
      chk("idle_hold", {bus.pll_en_o, bus.clk_cfg_o, bus.core_sel_o, bus.busy_o}, RST_VEC);

      // Minimum latency: immediate feedback, lock rises with pll_en.
      lk_mode = 0; lk_delay = 0; fb_mode = 0;
      sb.push_back({1'b0, 3'd4, 5'd3});
      do_start(3'd4, 5'd3);
      chk("lat_busy", bus.busy_o, 1);
      chk("lat_park_sel", bus.core_sel_o, 5'd1);
      n = 0;
      while (!bus.done_o && n < 100) begin
         tick();
         n = n + 1;
      end
      chk("lat_cycles", n, 1 + 2 * SETTLE + 2 + STABLE + 1);
      outcome("lat");

      // Nominal: late feedback, lock 10 cycles into PLL_ON.
      lk_mode = 0; lk_delay = 10; fb_mode = 1;
      sb.push_back({1'b0, 3'd5, 5'd2});
      do_start(3'd5, 5'd2);
      chk("nom_err_clr", bus.err_o, 0);
      chk("nom_park_sel", bus.core_sel_o, 5'd1);
      prev = bus.core_sel_o;
      chg  = 0;
      n    = 0;
      while (!bus.done_o && n < 200) begin
         tick();
         n = n + 1;
         if (bus.core_sel_o != prev) chg = chg + 1;
         prev = bus.core_sel_o;
      end
      chk("nom_sel_changes", chg, 1);
      outcome("nom");

      // Lock timeout.
      lk_mode = 1; fb_mode = 0;
      sb.push_back({1'b1, 3'd2, 5'd1});
      do_start(3'd2, 5'd6);
      wait_sig(0, 5'd0, 50, "tmo_off");
      wait_sig(0, 5'd1, 100, "tmo_on");
      n = 0;
      while (!bus.err_o && n < 200) begin
         tick();
         n = n + 1;
      end
      chk("tmo_cycles", n, TMO);
      outcome("tmo");
      repeat (5) tick();
      chk("tmo_err_sticky", bus.err_o, 1);

      // Glitchy lock never reaches stability, then a clean retry.
      lk_mode = 2;
      sb.push_back({1'b1, 3'd3, 5'd1});
      do_start(3'd3, 5'd4);
      chk("glitch_err_clr", bus.err_o, 0);
      wait_end(300, "glitch");
      outcome("glitch");
      lk_mode = 0; lk_delay = 0;
      sb.push_back({1'b0, 3'd3, 5'd4});
      do_start(3'd3, 5'd4);
      chk("retry_err_clr", bus.err_o, 0);
      wait_end(200, "retry");
      outcome("retry");

      // Lock lost while waiting for switch feedback.
      fb_mode = 2; fb_hold = 5'd1;
      sb.push_back({1'b1, 3'd6, 5'd1});
      do_start(3'd6, 5'd2);
      wait_sig(1, 5'd2, 200, "loss_switch");
      lk_mode = 1;
      wait_end(20, "loss");
      outcome("loss");

      // Start during CFG must be dropped.
      lk_mode = 0; fb_mode = 0;
      sb.push_back({1'b0, 3'd7, 5'd5});
      do_start(3'd7, 5'd5);
      wait_sig(2, 5'd7, 100, "ign_cfg");
      d0 = n_done;
      do_start(3'd1, 5'd9);
      wait_end(200, "ign");
      outcome("ign");
      repeat (60) tick();
      chk("ign_done_count", n_done - d0, 1);
      chk("ign_idle", bus.busy_o, 0);

      // Reset in PLL_ON.
      lk_mode = 1;
      do_start(3'd2, 5'd3);
      wait_sig(0, 5'd0, 50, "rst_off");
      wait_sig(0, 5'd1, 100, "rst_on");
      d0 = n_done;
      #3;
      rst_i = 1'b1;
      #1;
      chk("rst_mid_outs", {bus.pll_en_o, bus.clk_cfg_o, bus.core_sel_o, bus.busy_o}, RST_VEC);
      chk("rst_mid_flags", {bus.done_o, bus.err_o}, 2'b00);
      tick();
      rst_i = 1'b0;
      tick();
      chk("rst_no_done", n_done - d0, 0);
      chk("rst_no_err", bus.err_o, 0);
      lk_mode = 0;
      sb.push_back({1'b0, 3'd2, 5'd3});
      do_start(3'd2, 5'd3);
      wait_end(200, "post_rst");
      outcome("post_rst");

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
